mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents an operation
- ex_mem_control  in  8  one-hot {lb,lbu,lh,lhu,lw,sb,sh,sw}, bit 7 = lb
- ex_addr  in  32  effective address
- ex_wdata  in  32  store data (rt value)
- ex_dest  in  5  load destination register
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  full byte address
- data_wstrb  out  4  byte enables, writes only
- data_wdata  out  32  lane-aligned store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  raw read word
- mem_stall  out  1  freeze upstream stages
- mem_valid  out  1  one-cycle completion pulse
- mem_write_regfile  out  1  completed load writes mem_dest
- mem_dest  out  5  load destination
- mem_rdata  out  32  extended load result
- addr_err_load  out  1  AdEL with mem_valid
- addr_err_store  out  1  AdES with mem_valid
- badvaddr  out  32  faulting address
REQ-002 SHALL use exactly one clock (clk) and an asynchronous active-low reset (resetn).

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-004 SHALL accept an op in IDLE or DONE when ex_valid=1 and ex_mem_control!=0; it latches op, addr, wdata and dest, then enters REQ (aligned) or DONE (misaligned).
REQ-005 SHALL ignore ex_valid with ex_mem_control=0; with multiple bits set, SHALL use the highest set bit.
REQ-006 Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0. SHALL issue no bus request, enter DONE, set addr_err_load (loads) or addr_err_store (stores), and set badvaddr=addr.
REQ-007 In REQ, data_req SHALL be 1 with data_wr, data_size, data_addr, data_wstrb and data_wdata held stable; data_addr_ok=1 SHALL move to WAIT, otherwise stay in REQ.
REQ-008 In WAIT, data_req SHALL be 0; data_data_ok=1 SHALL move to DONE and latch the result. data_data_ok outside WAIT SHALL be ignored.
REQ-009 DONE SHALL last one cycle with mem_valid=1, then return to IDLE unless a new op is accepted.
REQ-010 mem_stall SHALL be 1 in REQ and WAIT; 0 in IDLE and DONE.
REQ-011 Store lanes:
- sb: wstrb=1<<addr[1:0], wdata={4{byte}}
- sh: wstrb = addr[1] ? 1100 : 0011, wdata={2{half}}
- sw: wstrb=1111, wdata=ex_wdata
REQ-012 Loads SHALL select the lane from data_rdata by addr[1:0]: lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word. data_wstrb SHALL be 0 for reads.
REQ-013 mem_write_regfile SHALL be 1 only in DONE for a load without address error; stores and faults SHALL give mem_write_regfile=0 and mem_rdata=0.
REQ-014 Best-case aligned latency: accept at cycle N, REQ at N+1 (addr_ok same cycle), WAIT at N+2, data_ok at N+2, mem_valid at N+3.

Reset
REQ-015 resetn=0 SHALL immediately force IDLE and drive all outputs to 0, including data_req and mem_stall.
REQ-016 Reset in REQ or WAIT SHALL abandon the transaction; no mem_valid is produced for it.

Verification
REQ-017 lw addr 0x1000, addr_ok at N+1, data_ok at N+2 with rdata 0xDEADBEEF -> mem_valid at N+3, mem_rdata 0xDEADBEEF, mem_write_regfile=1, mem_stall=1 only during N+1..N+2.
REQ-018 lb addr 0x1003, rdata 0x80FF1234 -> mem_rdata 0xFFFFFF80; lbu at the same address -> 0x00000080; lhu addr 0x1002 -> 0x000080FF.
REQ-019 sh addr 0x2002, wdata 0x0000ABCD -> data_wr=1, data_size=1, wstrb 1100, data_wdata 0xABCDABCD, mem_write_regfile=0.
REQ-020 lw addr 0x1001 -> data_req never 1, mem_valid next cycle, addr_err_load=1, badvaddr 0x1001; sw addr 0x3002 -> addr_err_store=1.
REQ-021 addr_ok held low 3 cycles, then data_ok 2 cycles after -> request fields stable throughout, mem_stall high throughout, one mem_valid pulse.
REQ-022 resetn low while in WAIT, later data_ok=1 -> IDLE, all outputs 0, no mem_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a req/addr_ok/data_ok data bus.
// Accepts one op at a time, aligns store lanes, extends load results, and flags
// misaligned accesses as AdEL/AdES without touching the bus.
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [7:0]  ex_mem_control,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_dest,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_stall,
    output logic        mem_valid,
    output logic        mem_write_regfile,
    output logic [4:0]  mem_dest,
    output logic [31:0] mem_rdata,
    output logic        addr_err_load,
    output logic        addr_err_store,
    output logic [31:0] badvaddr
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;
    typedef enum logic [2:0] {OpLb, OpLbu, OpLh, OpLhu, OpLw, OpSb, OpSh, OpSw} op_e;

    state_e      state_q, state_d;
    op_e         op_sel, op_q;
    logic        accept;
    logic        misaligned;
    logic        sel_store;
    logic [1:0]  sel_size;
    logic [3:0]  sel_wstrb;
    logic [31:0] sel_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    logic [31:0] addr_q;
    logic [4:0]  dest_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic        is_load_q;
    logic        err_load_q;
    logic        err_store_q;
    logic [31:0] rdata_q;
    logic        done;

    // Decode the control vector; the highest set bit wins when several are set.
    always_comb begin
        op_sel = OpSw;
        if (ex_mem_control[7])      op_sel = OpLb;
        else if (ex_mem_control[6]) op_sel = OpLbu;
        else if (ex_mem_control[5]) op_sel = OpLh;
        else if (ex_mem_control[4]) op_sel = OpLhu;
        else if (ex_mem_control[3]) op_sel = OpLw;
        else if (ex_mem_control[2]) op_sel = OpSb;
        else if (ex_mem_control[1]) op_sel = OpSh;
        else                        op_sel = OpSw;
    end

    // Per-op alignment check, transfer size and store lane placement.
    always_comb begin
        misaligned = 1'b0;
        sel_store  = 1'b0;
        sel_size   = 2'd0;
        sel_wstrb  = 4'b0000;
        sel_wdata  = 32'h0;
        unique case (op_sel)
            OpLb, OpLbu: begin
                sel_size = 2'd0;
            end
            OpLh, OpLhu: begin
                sel_size   = 2'd1;
                misaligned = ex_addr[0];
            end
            OpLw: begin
                sel_size   = 2'd2;
                misaligned = |ex_addr[1:0];
            end
            OpSb: begin
                sel_store = 1'b1;
                sel_size  = 2'd0;
                sel_wstrb = 4'b0001 << ex_addr[1:0];
                sel_wdata = {4{ex_wdata[7:0]}};
            end
            OpSh: begin
                sel_store  = 1'b1;
                sel_size   = 2'd1;
                misaligned = ex_addr[0];
                sel_wstrb  = ex_addr[1] ? 4'b1100 : 4'b0011;
                sel_wdata  = {2{ex_wdata[15:0]}};
            end
            OpSw: begin
                sel_store  = 1'b1;
                sel_size   = 2'd2;
                misaligned = |ex_addr[1:0];
                sel_wstrb  = 4'b1111;
                sel_wdata  = ex_wdata;
            end
        endcase
    end

    assign accept = ex_valid && (|ex_mem_control) &&
                    ((state_q == StIdle) || (state_q == StDone));

    // Next-state logic; faulting ops skip the bus and complete directly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = misaligned ? StDone : StReq;
            end
            StReq: begin
                if (data_addr_ok) state_d = StWait;
            end
            StWait: begin
                if (data_data_ok) state_d = StDone;
            end
            StDone: begin
                if (accept) state_d = misaligned ? StDone : StReq;
                else        state_d = StIdle;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned read word.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0: ld_byte = data_rdata[7:0];
            2'd1: ld_byte = data_rdata[15:8];
            2'd2: ld_byte = data_rdata[23:16];
            2'd3: ld_byte = data_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        ld_ext  = 32'h0;
        unique case (op_q)
            OpLb:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OpLbu: ld_ext = {24'h0, ld_byte};
            OpLh:  ld_ext = {{16{ld_half[15]}}, ld_half};
            OpLhu: ld_ext = {16'h0, ld_half};
            OpLw:  ld_ext = data_rdata;
            OpSb, OpSh, OpSw: ld_ext = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Request fields are captured on accept and held for the whole transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q        <= OpLb;
            addr_q      <= 32'h0;
            dest_q      <= 5'd0;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= 32'h0;
            is_load_q   <= 1'b0;
            err_load_q  <= 1'b0;
            err_store_q <= 1'b0;
        end else if (accept) begin
            op_q        <= op_sel;
            addr_q      <= ex_addr;
            dest_q      <= ex_dest;
            wr_q        <= sel_store;
            size_q      <= sel_size;
            wstrb_q     <= sel_wstrb;
            wdata_q     <= sel_wdata;
            is_load_q   <= !sel_store;
            err_load_q  <= misaligned && !sel_store;
            err_store_q <= misaligned && sel_store;
        end
    end

    // Load result is captured only when data_ok arrives in WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                              rdata_q <= 32'h0;
        else if (state_q == StWait && data_data_ok) rdata_q <= ld_ext;
    end

    assign done = (state_q == StDone);

    assign data_req   = (state_q == StReq);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;

    assign mem_stall         = (state_q == StReq) || (state_q == StWait);
    assign mem_valid         = done;
    assign mem_write_regfile = done && is_load_q && !err_load_q;
    assign mem_dest          = done ? dest_q : 5'd0;
    assign mem_rdata         = mem_write_regfile ? rdata_q : 32'h0;
    assign addr_err_load     = done && err_load_q;
    assign addr_err_store    = done && err_store_q;
    assign badvaddr          = (done && (err_load_q || err_store_q)) ? addr_q : 32'h0;

endmodule
